// File: rtl/ins_cache_refill.sv
// Instruction-cache line refill: requests a DDR burst on a miss, then drains
// the DDR-to-icache FIFO into the cache, checking packet sequence numbers.
module ins_cache_refill #(
    parameter int ISA_WIDTH        = 30,
    parameter int DDR_ADDR_WIDTH   = 28,
    parameter int ISA_DEPTH        = 72,
    parameter int CACHE_ADDR_WIDTH = 7
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        miss_req,
    input  logic [DDR_ADDR_WIDTH-1:0]   miss_addr,
    output logic                        busy,
    output logic                        refill_done,
    output logic [DDR_ADDR_WIDTH-1:0]   line_base,
    output logic                        ins_read_req,
    output logic [DDR_ADDR_WIDTH-1:0]   ins_read_addr,
    output logic [7:0]                  ins_read_len,
    input  logic                        ins_reading,
    input  logic                        fifo_empty,
    output logic                        fifo_rd_en,
    input  logic [ISA_WIDTH+8:0]        fifo_dout,
    output logic                        cache_wr_en,
    output logic [CACHE_ADDR_WIDTH-1:0] cache_wr_addr,
    output logic [ISA_WIDTH-1:0]        cache_wr_data,
    output logic                        seq_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_FILL,
        S_DONE
    } state_t;

    localparam logic [7:0] DEPTH8 = 8'(ISA_DEPTH);

    state_t                      r_state;
    state_t                      w_next;
    logic [7:0]                  r_rcv_cnt;
    logic                        r_pop_d;
    logic [DDR_ADDR_WIDTH-1:0]   r_line_base;
    logic                        r_wr_en;
    logic [CACHE_ADDR_WIDTH-1:0] r_wr_addr;
    logic [ISA_WIDTH-1:0]        r_wr_data;
    logic                        r_seq_err;

    logic                        w_pop;
    logic                        w_take;
    logic [ISA_WIDTH-1:0]        w_ins;
    logic [7:0]                  w_cnt;
    logic                        w_valid;

    assign w_ins   = fifo_dout[ISA_WIDTH+8:9];
    assign w_cnt   = fifo_dout[8:1];
    assign w_valid = fifo_dout[0];

    // Only packets popped while filling count; anything past the line is dropped.
    assign w_take = r_pop_d & w_valid & (r_state == S_FILL)
                  & (r_rcv_cnt < DEPTH8);

    always_comb begin
        w_next = r_state;
        w_pop  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (miss_req) w_next = S_REQ;
                else          w_pop  = ~fifo_empty;
            end
            S_REQ: begin
                if (ins_reading) w_next = S_FILL;
            end
            S_FILL: begin
                w_pop = ~fifo_empty;
                if (r_rcv_cnt == DEPTH8) w_next = S_DONE;
            end
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_rcv_cnt   <= '0;
            r_pop_d     <= 1'b0;
            r_line_base <= '0;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_seq_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_pop_d <= w_pop;
            r_wr_en <= w_take;
            if (r_state == S_IDLE && miss_req) begin
                r_line_base <= miss_addr;
                r_rcv_cnt   <= '0;
                r_seq_err   <= 1'b0;
            end
            if (w_take) begin
                r_wr_addr <= CACHE_ADDR_WIDTH'(r_rcv_cnt);
                r_wr_data <= w_ins;
                r_rcv_cnt <= r_rcv_cnt + 8'd1;
                if (w_cnt != r_rcv_cnt) r_seq_err <= 1'b1;
            end
        end
    end

    assign busy          = (r_state != S_IDLE);
    assign refill_done   = (r_state == S_DONE);
    assign ins_read_req  = (r_state == S_REQ);
    assign ins_read_addr = r_line_base;
    assign ins_read_len  = DEPTH8;
    assign line_base     = r_line_base;
    // Gated so the pop strobe is quiet while reset is held.
    assign fifo_rd_en    = w_pop & rst_n;
    assign cache_wr_en   = r_wr_en;
    assign cache_wr_addr = r_wr_addr;
    assign cache_wr_data = r_wr_data;
    assign seq_err       = r_seq_err;

endmodule

// File: tb/tb_ins_cache_refill.sv
// Bench for ins_cache_refill: table of refill scenarios against a FIFO model,
// plus hand sequences for reset mid-refill and stale-entry flushing.
module tb_ins_cache_refill;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        miss_req;
    logic [27:0] miss_addr;
    logic        busy;
    logic        refill_done;
    logic [27:0] line_base;
    logic        ins_read_req;
    logic [27:0] ins_read_addr;
    logic [7:0]  ins_read_len;
    logic        ins_reading;
    logic        fifo_empty = 1'b1;
    logic        fifo_rd_en;
    logic [38:0] fifo_dout = '0;
    logic        cache_wr_en;
    logic [6:0]  cache_wr_addr;
    logic [29:0] cache_wr_data;
    logic        seq_err;

    ins_cache_refill dut (
        .clk(clk), .rst_n(rst_n),
        .miss_req(miss_req), .miss_addr(miss_addr),
        .busy(busy), .refill_done(refill_done), .line_base(line_base),
        .ins_read_req(ins_read_req), .ins_read_addr(ins_read_addr),
        .ins_read_len(ins_read_len), .ins_reading(ins_reading),
        .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
        .fifo_dout(fifo_dout),
        .cache_wr_en(cache_wr_en), .cache_wr_addr(cache_wr_addr),
        .cache_wr_data(cache_wr_data), .seq_err(seq_err)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_err = 0;
    int          cyc = 0;
    bit          gap_mode = 1'b0;
    logic [38:0] q[$];
    logic [6:0]  log_addr[$];
    logic [29:0] log_data[$];
    int          n_done = 0;
    int          done_cyc = 0;

    typedef struct {
        logic [27:0] addr;
        bit          gap;
        bit          inval;
        int          bad;
        bit          mif;
        bit          exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vt[5];

    always @(posedge clk) cyc <= cyc + 1;

    // FIFO model: data appears one cycle after the pop.
    always @(posedge clk)
        if (fifo_rd_en && !fifo_empty) fifo_dout <= q.pop_front();

    always @(negedge clk)
        fifo_empty = (q.size() == 0) || (gap_mode && cyc[0]);

    always @(negedge clk) begin
        if (cache_wr_en) begin
            log_addr.push_back(cache_wr_addr);
            log_data.push_back(cache_wr_data);
        end
        if (refill_done) begin
            n_done++;
            done_cyc = cyc;
        end
    end

    function automatic logic [29:0] ins_of(int k, logic [27:0] base);
        return 30'(base) ^ 30'(k * 32'h0001_0203);
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push_line(logic [27:0] base, bit inval, int bad, int n);
        for (int k = 0; k < n; k++) begin
            if (inval && (k % 3 == 1))
                q.push_back({30'h3FFF_FFFF, 8'hEE, 1'b0});
            q.push_back({ins_of(k, base), 8'((k == bad) ? 9 : k), 1'b1});
        end
    endtask

    task automatic run(input vec_t v);
        int c_fill;
        int bad;
        log_addr.delete();
        log_data.delete();
        n_done   = 0;
        gap_mode = v.gap;
        tick();
        miss_req  = 1'b1;
        miss_addr = v.addr;
        tick();
        miss_req = 1'b0;
        chk("req_busy", 64'(busy), 64'd1);
        chk("req_line_base", 64'(line_base), 64'(v.addr));
        chk("req_read_req", 64'(ins_read_req), 64'd1);
        chk("req_read_addr", 64'(ins_read_addr), 64'(v.addr));
        chk("req_read_len", 64'(ins_read_len), 64'd72);
        chk("req_seq_clr", 64'(seq_err), 64'd0);
        push_line(v.addr, v.inval, v.bad, 74);
        tick();
        tick();
        ins_reading = 1'b1;
        c_fill = cyc + 1;
        tick();
        ins_reading = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (v.mif && i == 10) begin
                miss_req  = 1'b1;
                miss_addr = 28'hABCDEF0;
            end
            if (v.mif && i == 11) begin
                miss_req = 1'b0;
                chk("fill_busy", 64'(busy), 64'd1);
                chk("fill_line_base", 64'(line_base), 64'(v.addr));
            end
            if (n_done > 0) break;
            tick();
        end
        chk("done_seen", 64'(n_done > 0), 64'd1);
        for (int i = 0; i < 12; i++) tick();
        chk("done_once", 64'(n_done), 64'd1);
        chk("wr_count", 64'(log_addr.size()), 64'd72);
        bad = 0;
        for (int i = 0; i < log_addr.size(); i++)
            if (log_addr[i] != 7'(i) || log_data[i] != ins_of(i, v.addr))
                bad++;
        chk("wr_order", 64'(bad), 64'd0);
        chk("seq_err", 64'(seq_err), 64'(v.exp_err));
        if (v.exp_lat != 0)
            chk("done_latency", 64'(done_cyc - c_fill), 64'(v.exp_lat));
        chk("idle_flushed", 64'(q.size()), 64'd0);
        chk("idle_busy", 64'(busy), 64'd0);
    endtask

    initial begin
        vt[0] = '{28'h0000100, 1'b0, 1'b0, -1, 1'b0, 1'b0, 74};
        vt[1] = '{28'h0000200, 1'b1, 1'b0, -1, 1'b0, 1'b0, 0};
        vt[2] = '{28'h0000300, 1'b0, 1'b1, -1, 1'b0, 1'b0, 0};
        vt[3] = '{28'h0000400, 1'b0, 1'b0, 5, 1'b0, 1'b1, 74};
        vt[4] = '{28'h0000500, 1'b0, 1'b0, -1, 1'b1, 1'b0, 74};

        rst_n       = 1'b0;
        miss_req    = 1'b0;
        miss_addr   = '0;
        ins_reading = 1'b0;
        tick();
        tick();
        chk("rst_ctrl", 64'({busy, refill_done, ins_read_req, fifo_rd_en,
                             cache_wr_en, seq_err}), 64'd0);
        chk("rst_line_base", 64'(line_base), 64'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 5; i++) run(vt[i]);

        // Abandon a line at the 30th write, then flush stale residue.
        log_addr.delete();
        log_data.delete();
        gap_mode  = 1'b0;
        tick();
        miss_req  = 1'b1;
        miss_addr = 28'h0000600;
        tick();
        miss_req = 1'b0;
        push_line(28'h0000600, 1'b0, -1, 74);
        tick();
        tick();
        ins_reading = 1'b1;
        tick();
        ins_reading = 1'b0;
        for (int i = 0; i < 500 && log_addr.size() < 30; i++) tick();
        chk("pre_rst_writes", 64'(log_addr.size()), 64'd30);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ctrl", 64'({busy, refill_done, ins_read_req, fifo_rd_en,
                                 cache_wr_en, seq_err}), 64'd0);
        chk("mid_rst_base", 64'({line_base, ins_read_addr}), 64'd0);
        chk("mid_rst_wr", 64'({cache_wr_addr, cache_wr_data}), 64'd0);
        q.delete();
        push_line(28'h0000700, 1'b0, -1, 10);
        log_addr.delete();
        log_data.delete();
        n_done = 0;
        tick();
        tick();
        chk("rst_hold_fifo", 64'(q.size()), 64'd10);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        chk("stale_flushed", 64'(q.size()), 64'd0);
        chk("stale_no_write", 64'(log_addr.size()), 64'd0);
        chk("stale_no_done", 64'(n_done), 64'd0);

        run(vt[0]);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
